datapath_sequencer: RTL and testbench

Multi-cycle control FSM that fetches 16-bit instructions, holds PC and IR, and drives every control input of the 16-bit register-file/shifter/ALU datapath: register selects, load enables, operand/writeback muxes and ALU/shift codes. It also drives the shared instruction/data memory port. It sits between memory and the datapath inside the CPU top level.

---
 rtl/datapath_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions over the shared memory
// port, holds PC/IR, and drives every control input of the register-file/shifter/ALU datapath.
module datapath_sequencer #(
   parameter int PC_W   = 9,
   parameter int RST_PC = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [15:0]     mdata,
   input  logic [PC_W-1:0] data_address,
   output logic [2:0]      reg_w,
   output logic [2:0]      reg_a,
   output logic [2:0]      reg_b,
   output logic            write,
   output logic            loada,
   output logic            loadb,
   output logic            loadc,
   output logic            loads,
   output logic            loadm,
   output logic            asel,
   output logic            bsel,
   output logic            csel,
   output logic [3:0]      vsel,
   output logic [1:0]      op,
   output logic [1:0]      shift,
   output logic [15:0]     sximm5,
   output logic [15:0]     sximm8,
   output logic [PC_W-1:0] PC,
   output logic [1:0]      mem_cmd,
   output logic [PC_W-1:0] mem_addr,
   output logic            halted
);

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE, S_WIMM, S_GETA, S_GETB, S_ALU,
      S_WB, S_ADDR, S_RD1, S_RD2, S_WBM, S_STC, S_STW, S_HALT
   } state_t;

   localparam logic [4:0] C_MOVI = 5'b11010;
   localparam logic [4:0] C_MOVR = 5'b11000;
   localparam logic [4:0] C_ADD  = 5'b10100;
   localparam logic [4:0] C_CMP  = 5'b10101;
   localparam logic [4:0] C_AND  = 5'b10110;
   localparam logic [4:0] C_MVN  = 5'b10111;
   localparam logic [4:0] C_LDR  = 5'b01100;
   localparam logic [4:0] C_STR  = 5'b10000;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;

   logic [4:0] w_opc;
   logic [2:0] w_rn;
   logic [2:0] w_rd;
   logic [2:0] w_rm;
   logic [1:0] w_sh;
   logic       w_alu_asel;

   assign w_opc      = r_ir[15:11];
   assign w_rn       = r_ir[10:8];
   assign w_rd       = r_ir[7:5];
   assign w_sh       = r_ir[4:3];
   assign w_rm       = r_ir[2:0];
   // MOV reg and MVN have no A operand, so the ALU sees zero on that side.
   assign w_alu_asel = (w_opc == C_MOVR) || (w_opc == C_MVN);

   assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
   assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
   assign PC     = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RST;
         r_pc    <= PC_W'(RST_PC);
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IF2)   r_ir <= mdata;
         if (r_state == S_UPDPC) r_pc <= r_pc + PC_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    w_next = S_IF1;
         S_IF1:    w_next = S_IF2;
         S_IF2:    w_next = S_UPDPC;
         S_UPDPC:  w_next = S_DECODE;
         S_DECODE: begin
            case (w_opc)
               C_MOVI:                             w_next = S_WIMM;
               C_MOVR, C_MVN:                      w_next = S_GETB;
               C_ADD, C_CMP, C_AND, C_LDR, C_STR:  w_next = S_GETA;
               default:                            w_next = S_HALT;
            endcase
         end
         S_WIMM:   w_next = S_IF1;
         S_GETA:   w_next = (r_ir[15:13] == 3'b101) ? S_GETB : S_ADDR;
         S_GETB:   w_next = S_ALU;
         S_ALU:    w_next = (w_opc == C_CMP) ? S_IF1 : S_WB;
         S_WB:     w_next = S_IF1;
         S_ADDR:   w_next = (w_opc == C_LDR) ? S_RD1 : S_STC;
         S_RD1:    w_next = S_RD2;
         S_RD2:    w_next = S_WBM;
         S_WBM:    w_next = S_IF1;
         S_STC:    w_next = S_STW;
         S_STW:    w_next = S_IF1;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_RST;
      endcase
   end

   always_comb begin
      reg_w    = '0;
      reg_a    = '0;
      reg_b    = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      loadm    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      csel     = 1'b0;
      vsel     = '0;
      op       = '0;
      shift    = '0;
      mem_cmd  = CMD_NONE;
      mem_addr = data_address;
      halted   = 1'b0;
      case (r_state)
         S_RST:    mem_addr = '0;
         S_IF1, S_IF2: begin
            mem_cmd  = CMD_READ;
            mem_addr = r_pc;
         end
         S_UPDPC, S_DECODE: mem_addr = r_pc;
         S_WIMM: begin
            reg_w = w_rn;
            vsel  = 4'b0100;
            write = 1'b1;
         end
         S_GETA: begin
            reg_a = w_rn;
            loada = 1'b1;
         end
         S_GETB: begin
            reg_b = w_rm;
            loadb = 1'b1;
         end
         S_ALU: begin
            // IR op already equals the required ALU code for every ALU-class instruction.
            asel  = w_alu_asel;
            op    = r_ir[12:11];
            shift = w_sh;
            if (w_opc == C_CMP) loads = 1'b1;
            else                loadc = 1'b1;
         end
         S_WB: begin
            reg_w = w_rd;
            vsel  = 4'b0001;
            write = 1'b1;
         end
         S_ADDR: begin
            bsel  = 1'b1;
            loadm = 1'b1;
         end
         S_RD1, S_RD2: mem_cmd = CMD_READ;
         S_WBM: begin
            reg_w = w_rd;
            vsel  = 4'b0010;
            write = 1'b1;
         end
         S_STC: begin
            reg_b = w_rd;
            csel  = 1'b1;
            loadc = 1'b1;
         end
         S_STW:  mem_cmd = CMD_WRITE;
         S_HALT: halted  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: an instruction-level model predicts every
// control event (with its cycle); a negedge monitor pops and compares what the DUT shows.
module tb_datapath_sequencer;
   localparam int PC_W = 9;

   localparam int K_READ  = 0;
   localparam int K_MEMW  = 1;
   localparam int K_LOADA = 2;
   localparam int K_LOADB = 3;
   localparam int K_LOADM = 4;
   localparam int K_LOADC = 5;
   localparam int K_LOADS = 6;
   localparam int K_WREG  = 7;
   localparam int K_BAD   = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [15:0]     mdata = 16'h0;
   logic [PC_W-1:0] data_address = '0;
   logic [2:0]      reg_w, reg_a, reg_b;
   logic            write, loada, loadb, loadc, loads, loadm, asel, bsel, csel;
   logic [3:0]      vsel;
   logic [1:0]      op, shift, mem_cmd;
   logic [15:0]     sximm5, sximm8;
   logic [PC_W-1:0] PC, mem_addr;
   logic            halted;

   datapath_sequencer #(.PC_W(PC_W), .RST_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .mdata(mdata), .data_address(data_address),
      .reg_w(reg_w), .reg_a(reg_a), .reg_b(reg_b), .write(write), .loada(loada),
      .loadb(loadb), .loadc(loadc), .loads(loads), .loadm(loadm), .asel(asel),
      .bsel(bsel), .csel(csel), .vsel(vsel), .op(op), .shift(shift),
      .sximm5(sximm5), .sximm8(sximm8), .PC(PC), .mem_cmd(mem_cmd),
      .mem_addr(mem_addr), .halted(halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem [0:511];
   always @(posedge clk) if (mem_cmd == 2'b01) mdata <= mem[mem_addr];

   typedef struct { int cyc; int kind; logic [31:0] data; } ev_t;
   ev_t q[$];
   int total = 0;
   int bad = 0;

   function automatic logic [31:0] ldc(input logic a, input logic b, input logic c,
                                       input logic [1:0] o, input logic [1:0] s,
                                       input logic [2:0] rb);
      return 32'({a, b, c, o, s, rb});
   endfunction

   function automatic logic [127:0] outs();
      return 128'({reg_w, reg_a, reg_b, write, loada, loadb, loadc, loads, loadm, asel,
                   bsel, csel, vsel, op, shift, sximm5, sximm8, PC, mem_cmd, mem_addr, halted});
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int k, input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.kind = k; e.data = d;
      q.push_back(e);
   endtask

   task automatic observe(input int k, input logic [31:0] d);
      ev_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event cyc=%0d kind=%0d data=%0h required=none", cyc, k, d);
      end else begin
         e = q.pop_front();
         if (e.cyc != cyc || e.kind != k || e.data != d) begin
            bad++;
            $display("FAIL event actual cyc=%0d kind=%0d data=%0h required cyc=%0d kind=%0d data=%0h",
                     cyc, k, d, e.cyc, e.kind, e.data);
         end
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_cmd == 2'b01) observe(K_READ, 32'(mem_addr));
         if (mem_cmd == 2'b10) observe(K_MEMW, 32'(mem_addr));
         if (mem_cmd == 2'b11) observe(K_BAD, 32'(mem_cmd));
         if (loada) observe(K_LOADA, 32'(reg_a));
         if (loadb) observe(K_LOADB, 32'(reg_b));
         if (loadm) observe(K_LOADM, 32'({asel, bsel, op, shift, sximm5}));
         if (loadc) observe(K_LOADC, ldc(asel, bsel, csel, op, shift, reg_b));
         if (loads) observe(K_LOADS, 32'({asel, bsel, op, shift}));
         if (write) observe(K_WREG, 32'({reg_w, vsel, (vsel == 4'b0100) ? sximm8 : 16'h0}));
      end
   end

   // Instruction-level reference: walks the program in mem from PC=0 and predicts events.
   task automatic model_run(input int t0, input logic [PC_W-1:0] da,
                            output int hc, output logic [PC_W-1:0] hpc);
      logic [PC_W-1:0] pc;
      logic [15:0] ir, sx5, sx8;
      logic [2:0] rn, rd, rm;
      logic [1:0] sh, of;
      int t;
      pc = '0; t = t0; hc = t0; hpc = '0;
      for (int n = 0; n < 600; n++) begin
         ir = mem[pc];
         rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0]; of = ir[12:11];
         sx5 = {{11{ir[4]}}, ir[4:0]};
         sx8 = {{8{ir[7]}}, ir[7:0]};
         push(t, K_READ, 32'(pc));
         push(t + 1, K_READ, 32'(pc));
         pc = pc + 1'b1;
         case (ir[15:11])
            5'b11010: begin
               push(t + 4, K_WREG, 32'({rn, 4'b0100, sx8}));
               t += 5;
            end
            5'b11000: begin
               push(t + 4, K_LOADB, 32'(rm));
               push(t + 5, K_LOADC, ldc(1'b1, 1'b0, 1'b0, 2'b00, sh, 3'd0));
               push(t + 6, K_WREG, 32'({rd, 4'b0001, 16'h0}));
               t += 7;
            end
            5'b10100, 5'b10110: begin
               push(t + 4, K_LOADA, 32'(rn));
               push(t + 5, K_LOADB, 32'(rm));
               push(t + 6, K_LOADC, ldc(1'b0, 1'b0, 1'b0, of, sh, 3'd0));
               push(t + 7, K_WREG, 32'({rd, 4'b0001, 16'h0}));
               t += 8;
            end
            5'b10101: begin
               push(t + 4, K_LOADA, 32'(rn));
               push(t + 5, K_LOADB, 32'(rm));
               push(t + 6, K_LOADS, 32'({1'b0, 1'b0, 2'b01, sh}));
               t += 7;
            end
            5'b10111: begin
               push(t + 4, K_LOADB, 32'(rm));
               push(t + 5, K_LOADC, ldc(1'b1, 1'b0, 1'b0, 2'b11, sh, 3'd0));
               push(t + 6, K_WREG, 32'({rd, 4'b0001, 16'h0}));
               t += 7;
            end
            5'b01100: begin
               push(t + 4, K_LOADA, 32'(rn));
               push(t + 5, K_LOADM, 32'({1'b0, 1'b1, 2'b00, 2'b00, sx5}));
               push(t + 6, K_READ, 32'(da));
               push(t + 7, K_READ, 32'(da));
               push(t + 8, K_WREG, 32'({rd, 4'b0010, 16'h0}));
               t += 9;
            end
            5'b10000: begin
               push(t + 4, K_LOADA, 32'(rn));
               push(t + 5, K_LOADM, 32'({1'b0, 1'b1, 2'b00, 2'b00, sx5}));
               push(t + 6, K_LOADC, ldc(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, rd));
               push(t + 7, K_MEMW, 32'(da));
               t += 8;
            end
            default: begin
               hc = t + 4; hpc = pc;
               return;
            end
         endcase
      end
      hc = t;
   endtask

   task automatic goto_cyc(input int n);
      int k;
      k = 0;
      @(negedge clk);
      while (cyc < n && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (cyc != n) begin
         total++; bad++;
         $display("FAIL goto_cyc reached=%0d required=%0d", cyc, n);
      end
   endtask

   task automatic start_prog(input logic [PC_W-1:0] da, output int t0, output int hc,
                             output logic [PC_W-1:0] hpc);
      data_address = da;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_outputs", outs(), 128'h0);
      q.delete();
      @(posedge clk); #3;
      rst_n = 1'b1;
      t0 = cyc + 1;
      model_run(t0, da, hc, hpc);
   endtask

   task automatic finish_prog(input int hc, input logic [PC_W-1:0] hpc);
      bit ok;
      goto_cyc(hc - 1);
      chk("not_yet_halted", 128'(halted), 128'h0);
      goto_cyc(hc);
      chk("halted", 128'(halted), 128'h1);
      chk("halt_pc", 128'(PC), 128'(hpc));
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!halted || PC != hpc || mem_cmd != 2'b00) ok = 1'b0;
      end
      chk("halt_hold_20", 128'(ok), 128'h1);
      chk("queue_drained", 128'(q.size()), 128'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, hc, nl, nw, ns;
      logic [PC_W-1:0] hpc;
      bit ok;
      logic [15:0] base [0:7];

      // Directed program from the plan
      for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
      mem[0] = 16'hD007; mem[1] = 16'hD1FE; mem[2] = 16'hA148; mem[3] = 16'hA900;
      mem[4] = 16'h6064; mem[5] = 16'h8064; mem[6] = 16'hE000;
      start_prog(9'd11, t0, hc, hpc);
      goto_cyc(t0);
      chk("if1_cmd", 128'(mem_cmd), 128'h1);
      chk("if1_addr", 128'(mem_addr), 128'h0);
      chk("if1_pc", 128'(PC), 128'h0);
      goto_cyc(t0 + 3);
      chk("pc_after_updpc", 128'(PC), 128'h1);
      goto_cyc(t0 + 4);
      chk("wimm", 128'({write, reg_w, vsel, sximm8}), 128'({1'b1, 3'd0, 4'b0100, 16'h0007}));
      goto_cyc(t0 + 5);
      chk("second_if1", 128'({mem_cmd, mem_addr}), 128'({2'b01, 9'd1}));
      goto_cyc(t0 + 16);
      chk("add_alu", 128'({op, shift, loadc}), 128'({2'b00, 2'b01, 1'b1}));
      goto_cyc(t0 + 17);
      chk("add_wb", 128'({write, reg_w, vsel}), 128'({1'b1, 3'd2, 4'b0001}));
      goto_cyc(t0 + 18);
      nl = 0; nw = 0;
      for (int i = 0; i < 7; i++) begin
         nl += int'(loads); nw += int'(write);
         if (i < 6) @(negedge clk);
      end
      chk("cmp_loads_once", 128'(nl), 128'h1);
      chk("cmp_no_write", 128'(nw), 128'h0);
      goto_cyc(t0 + 31);
      chk("ldr_rd1", 128'({mem_cmd, mem_addr}), 128'({2'b01, 9'd11}));
      goto_cyc(t0 + 33);
      chk("ldr_wbm", 128'({write, reg_w, vsel}), 128'({1'b1, 3'd3, 4'b0010}));
      goto_cyc(t0 + 34);
      ns = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 6) chk("str_stc", 128'({csel, reg_b, loadc}), 128'({1'b1, 3'd3, 1'b1}));
         ns += int'(mem_cmd == 2'b10);
         if (i < 7) @(negedge clk);
      end
      chk("stw_once", 128'(ns), 128'h1);
      finish_prog(hc, hpc);

      // Undefined instruction halts
      mem[0] = 16'h0000;
      start_prog(9'd5, t0, hc, hpc);
      chk("undef_halt_cyc", 128'(hc - t0), 128'd4);
      finish_prog(hc, hpc);

      // Reset pulsed during ADD GETB, then restart from address 0
      mem[0] = 16'hA148; mem[1] = 16'hE000;
      start_prog(9'd7, t0, hc, hpc);
      goto_cyc(t0 + 4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", outs(), 128'h0);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (outs() != 128'h0) ok = 1'b0;
      end
      chk("reset_hold_quiet", 128'(ok), 128'h1);
      q.delete();
      start_prog(9'd7, t0, hc, hpc);
      goto_cyc(t0);
      chk("restart_fetch", 128'({mem_cmd, mem_addr, PC}), 128'({2'b01, 9'd0, 9'd0}));
      finish_prog(hc, hpc);

      // Random programs
      base[0] = 16'hD000; base[1] = 16'hC000; base[2] = 16'hA000; base[3] = 16'hA800;
      base[4] = 16'hB000; base[5] = 16'hB800; base[6] = 16'h6000; base[7] = 16'h8000;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
         for (int i = 0; i < 25; i++)
            mem[i] = base[$urandom_range(0, 7)] | 16'($urandom & 32'h7FF);
         mem[25] = 16'hE000;
         start_prog(9'($urandom_range(0, 511)), t0, hc, hpc);
         finish_prog(hc, hpc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
